// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: CSRRW/RS/RC read-modify-write bus initiator with trap-entry sequencer.
// The trap sequence and redirect target exist only when CSR_TRAP_EN is defined.
module csr_access_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  req_funct3_i,
  input  logic [11:0] req_csr_i,
  input  logic [4:0]  req_src_i,
  input  logic [31:0] req_rs1_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_illegal_o,
  input  logic        trap_i,
  input  logic [31:0] trap_cause_i,
  input  logic [31:0] trap_pc_i,
  output logic        trap_done_o,
  output logic [31:0] trap_target_o,
  output logic [31:0] csr_addr_o,
  output logic        csr_ren_o,
  output logic        csr_wen_o,
  output logic [31:0] csr_wdata_o,
  input  logic [31:0] csr_rdata_i,
  output logic        busy_o
);
`ifdef CSR_TRAP_EN
  typedef enum logic [3:0] {IDLE, RD, RCAP, WR, RSP, T_EPC, T_CAUSE, T_SRD, T_SCAP, T_SWR, T_VRD, T_VCAP, T_DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, RD, RCAP, WR, RSP} state_t;
`endif
  state_t state, state_n;
  logic [11:0] csr_q, addr;
  logic [31:0] op_q, old_q, new_val;
  logic [1:0]  kind_q;
  logic        skip_q, ill_q, accept;
  assign busy_o = state != IDLE;
`ifdef CSR_TRAP_EN
  logic [31:0] cause_q, target_q, mtvec_base;
  logic [31:2] pc_q;
  assign req_ready_o   = ~busy_o & ~trap_i & ~rst_i;
  assign mtvec_base    = {csr_rdata_i[31:2], 2'b00};
  assign trap_target_o = target_q;
`else
  logic unused_trap;
  assign unused_trap   = ^{trap_i, trap_cause_i, trap_pc_i};
  assign req_ready_o   = ~busy_o & ~rst_i;
  assign trap_done_o   = 1'b0;
  assign trap_target_o = '0;
`endif
  assign accept        = req_valid_i & req_ready_o;
  assign new_val       = kind_q == 2'b01 ? op_q : kind_q == 2'b10 ? old_q | op_q : old_q & ~op_q;
  assign csr_addr_o    = {20'b0, addr};
  assign rsp_valid_o   = state == RSP;
  assign rsp_rdata_o   = rsp_valid_o ? old_q : '0;
  assign rsp_illegal_o = rsp_valid_o & ill_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state  <= IDLE;
      csr_q  <= '0;
      op_q   <= '0;
      old_q  <= '0;
      kind_q <= '0;
      skip_q <= 1'b0;
      ill_q  <= 1'b0;
`ifdef CSR_TRAP_EN
      cause_q  <= '0;
      pc_q     <= '0;
      target_q <= '0;
`endif
    end else begin
      state <= state_n;
      if (accept) begin
        csr_q  <= req_csr_i;
        op_q   <= req_funct3_i[2] ? {27'b0, req_src_i} : req_rs1_i;
        kind_q <= req_funct3_i[1:0];
        skip_q <= req_funct3_i[1] && req_src_i == 5'd0;
        ill_q  <= req_funct3_i[1:0] == 2'b00;
        old_q  <= '0;
      end
      if (state == RCAP) old_q <= csr_rdata_i;
`ifdef CSR_TRAP_EN
      if (state == IDLE && trap_i) begin
        cause_q <= trap_cause_i;
        pc_q    <= trap_pc_i[31:2];
      end
      if (state == T_SCAP) old_q <= csr_rdata_i;
      // vectored mode only for interrupts (cause MSB set)
      if (state == T_VCAP)
        target_q <= (csr_rdata_i[1:0] == 2'b01 && cause_q[31]) ? mtvec_base + {cause_q[29:0], 2'b00} : mtvec_base;
`endif
    end
  always_comb begin
    state_n     = state;
    addr        = '0;
    csr_ren_o   = 1'b0;
    csr_wen_o   = 1'b0;
    csr_wdata_o = '0;
`ifdef CSR_TRAP_EN
    trap_done_o = 1'b0;
`endif
    case (state)
`ifdef CSR_TRAP_EN
      IDLE:    state_n = trap_i ? T_EPC : accept ? (req_funct3_i[1:0] == 2'b00 ? RSP : RD) : IDLE;
`else
      IDLE:    state_n = accept ? (req_funct3_i[1:0] == 2'b00 ? RSP : RD) : IDLE;
`endif
      RD:      begin csr_ren_o = 1'b1; addr = csr_q; state_n = RCAP; end
      RCAP:    state_n = skip_q ? RSP : WR;
      WR:      begin csr_wen_o = 1'b1; addr = csr_q; csr_wdata_o = new_val; state_n = RSP; end
      RSP:     state_n = IDLE;
`ifdef CSR_TRAP_EN
      T_EPC:   begin csr_wen_o = 1'b1; addr = 12'h341; csr_wdata_o = {pc_q, 2'b00}; state_n = T_CAUSE; end
      T_CAUSE: begin csr_wen_o = 1'b1; addr = 12'h342; csr_wdata_o = cause_q; state_n = T_SRD; end
      T_SRD:   begin csr_ren_o = 1'b1; addr = 12'h300; state_n = T_SCAP; end
      T_SCAP:  state_n = T_SWR;
      // MPP=11, MPIE<=MIE, MIE=0
      T_SWR:   begin
        csr_wen_o   = 1'b1;
        addr        = 12'h300;
        csr_wdata_o = {old_q[31:13], 2'b11, old_q[10:8], old_q[3], old_q[6:4], 1'b0, old_q[2:0]};
        state_n     = T_VRD;
      end
      T_VRD:   begin csr_ren_o = 1'b1; addr = 12'h305; state_n = T_VCAP; end
      T_VCAP:  state_n = T_DONE;
      T_DONE:  begin trap_done_o = 1'b1; state_n = IDLE; end
`endif
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_csr_access_ctrl.sv
// tb_csr_access_ctrl: randomized scoreboard bench for csr_access_ctrl with a CSR register-file model.
module tb_csr_access_ctrl;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready;
  logic [2:0] f3 = 0;
  logic [11:0] csr = 0;
  logic [4:0] src = 0;
  logic [31:0] rs1 = 0;
  logic rsp_valid, rsp_illegal;
  logic [31:0] rsp_rdata;
  logic trap = 0, trap_done;
  logic [31:0] tcause = 0, tpc = 0, trap_target;
  logic [31:0] addr, wdata, rdata = 0;
  logic ren, wen, busy;
  logic pre_en = 0;
  logic [11:0] pre_a = 0;
  logic [31:0] pre_d = 0;
  logic [31:0] mem [0:4095];
  logic [31:0] refm [0:4095];
  logic [11:0] csrs [6] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342};
  int cyc = 0, tests = 0, fails = 0;
  typedef struct {bit wr; logic [31:0] a; logic [31:0] d; int c;} bus_t;
  typedef struct {bit ill; logic [31:0] d; int c;} rsp_t;
  bus_t bq[$];
  rsp_t rq[$];
  rsp_t tq[$];

  always #5 clk = ~clk;

  csr_access_ctrl dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_funct3_i(f3), .req_csr_i(csr), .req_src_i(src), .req_rs1_i(rs1),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_illegal_o(rsp_illegal),
    .trap_i(trap), .trap_cause_i(tcause), .trap_pc_i(tpc), .trap_done_o(trap_done),
    .trap_target_o(trap_target), .csr_addr_o(addr), .csr_ren_o(ren), .csr_wen_o(wen),
    .csr_wdata_o(wdata), .csr_rdata_i(rdata), .busy_o(busy)
  );

  // register file: one-cycle registered read
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ren) rdata <= mem[addr[11:0]];
    if (wen) mem[addr[11:0]] <= wdata;
    if (pre_en) mem[pre_a] <= pre_d;
  end

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
    end
  endfunction

  function automatic void bad(string n);
    tests++;
    fails++;
    $display("FAIL %s (cycle %0d)", n, cyc);
  endfunction

  always @(negedge clk) begin : mon
    bus_t b;
    rsp_t r;
    if (!rst) begin
      chk("one_strobe", {31'b0, ren & wen}, 0);
      if (!ren && !wen) begin
        chk("idle_addr", addr, 0);
        chk("idle_wdata", wdata, 0);
      end
      if (ren || wen) begin
        if (bq.size() == 0) bad($sformatf("bus_unexpected ren=%b wen=%b addr=%h", ren, wen, addr));
        else begin
          b = bq.pop_front();
          chk("bus_dir_wen", {31'b0, wen}, {31'b0, b.wr});
          chk("bus_addr", addr, b.a);
          if (b.wr) chk("bus_wdata", wdata, b.d);
          chk("bus_cycle", cyc, b.c);
        end
      end
      if (rsp_valid) begin
        if (rq.size() == 0) bad("rsp_unexpected");
        else begin
          r = rq.pop_front();
          chk("rsp_rdata", rsp_rdata, r.d);
          chk("rsp_illegal", {31'b0, rsp_illegal}, {31'b0, r.ill});
          chk("rsp_cycle", cyc, r.c);
        end
      end
`ifdef CSR_TRAP_EN
      if (trap_done) begin
        if (tq.size() == 0) bad("trap_done_unexpected");
        else begin
          r = tq.pop_front();
          chk("trap_target", trap_target, r.d);
          chk("trap_cycle", cyc, r.c);
        end
      end
`else
      chk("trap_done_tied", {31'b0, trap_done}, 0);
      chk("trap_target_tied", trap_target, 0);
`endif
    end
  end

  task automatic wait_idle();
    int i = 0;
    @(negedge clk);
    while (busy && i < 40) begin @(negedge clk); i++; end
    if (busy) bad("idle_timeout");
  endtask

  task automatic drain(string n);
    int i = 0;
    while ((bq.size() + rq.size() + tq.size()) != 0 && i < 40) begin @(negedge clk); i++; end
    if ((bq.size() + rq.size() + tq.size()) != 0) begin
      bad({n, "_timeout"});
      bq.delete(); rq.delete(); tq.delete();
    end
  endtask

  task automatic preset(input logic [11:0] a, input logic [31:0] d);
    wait_idle();
    pre_a = a; pre_d = d; pre_en = 1;
    @(posedge clk); #1 pre_en = 0;
    refm[a] = d;
  endtask

  task automatic chk_reset_outs(string n);
    chk({n, "_ready"}, {31'b0, req_ready}, 0);
    chk({n, "_rsp"}, {30'b0, rsp_valid, rsp_illegal}, 0);
    chk({n, "_rdata"}, rsp_rdata, 0);
    chk({n, "_strobes"}, {29'b0, ren, wen, busy}, 0);
    chk({n, "_addr"}, addr, 0);
    chk({n, "_wdata"}, wdata, 0);
    chk({n, "_tdone"}, {31'b0, trap_done}, 0);
    chk({n, "_target"}, trap_target, 0);
  endtask

  // reference: funct3 semantics straight from the ISA rules; latencies relative to accept edge
  task automatic csr_op(input logic [2:0] f, input logic [11:0] c, input logic [4:0] s, input logic [31:0] r);
    logic [31:0] op, old, nv;
    bit skip;
    int acc;
    wait_idle();
    f3 = f; csr = c; src = s; rs1 = r; req_valid = 1;
    #1 chk("req_ready", {31'b0, req_ready}, 1);
    @(posedge clk); #1 acc = cyc; req_valid = 0;
    chk("busy_after_accept", {31'b0, busy}, 1);
    op = f[2] ? {27'b0, s} : r;
    if (f[1:0] == 2'b00) rq.push_back('{1'b1, 32'h0, acc});
    else begin
      old = refm[c];
      case (f[1:0])
        2'b01: nv = op;
        2'b10: nv = old | op;
        default: nv = old & ~op;
      endcase
      skip = f[1:0] != 2'b01 && s == 0;
      bq.push_back('{1'b0, {20'b0, c}, 32'h0, acc});
      if (!skip) begin
        bq.push_back('{1'b1, {20'b0, c}, nv, acc + 2});
        refm[c] = nv;
      end
      rq.push_back('{1'b0, old, skip ? acc + 2 : acc + 3});
    end
    drain("csr_op");
  endtask

`ifdef CSR_TRAP_EN
  function automatic logic [31:0] mstatus_entry(input logic [31:0] ms);
    logic [31:0] n = ms;
    n[7] = ms[3];
    n[3] = 1'b0;
    n[12:11] = 2'b11;
    return n;
  endfunction

  task automatic trap_seq(input logic [31:0] cause, input logic [31:0] pc, input bit with_req);
    logic [31:0] nms, base, tgt;
    int acc;
    wait_idle();
    trap = 1; tcause = cause; tpc = pc;
    req_valid = with_req; f3 = 3'b001; csr = 12'h340; rs1 = 32'hdead_beef;
    #1 chk("ready_during_trap", {31'b0, req_ready}, 0);
    @(posedge clk); #1 acc = cyc; trap = 0; req_valid = 0;
    nms = mstatus_entry(refm[12'h300]);
    base = refm[12'h305] & ~32'd3;
    tgt = (refm[12'h305][1:0] == 2'b01 && cause[31]) ? base + ((cause & 32'h7fff_ffff) << 2) : base;
    bq.push_back('{1'b1, 32'h341, pc & ~32'd3, acc});
    bq.push_back('{1'b1, 32'h342, cause, acc + 1});
    bq.push_back('{1'b0, 32'h300, 32'h0, acc + 2});
    bq.push_back('{1'b1, 32'h300, nms, acc + 4});
    bq.push_back('{1'b0, 32'h305, 32'h0, acc + 5});
    tq.push_back('{1'b0, tgt, acc + 7});
    refm[12'h341] = pc & ~32'd3;
    refm[12'h342] = cause;
    refm[12'h300] = nms;
    drain("trap");
    repeat (3) @(negedge clk);
    chk("target_hold", trap_target, tgt);
  endtask

  task automatic trap_reset(input logic [31:0] cause, input logic [31:0] pc);
    int acc, i = 0;
    wait_idle();
    trap = 1; tcause = cause; tpc = pc;
    @(posedge clk); #1 acc = cyc; trap = 0;
    bq.push_back('{1'b1, 32'h341, pc & ~32'd3, acc});
    bq.push_back('{1'b1, 32'h342, cause, acc + 1});
    bq.push_back('{1'b0, 32'h300, 32'h0, acc + 2});
    bq.push_back('{1'b1, 32'h300, mstatus_entry(refm[12'h300]), acc + 4});
    while (cyc < acc + 4 && i < 20) begin @(negedge clk); i++; end
    #1 chk("swr_wen_before_rst", {31'b0, wen}, 1);
    #1 rst = 1;
    #1 chk("rst_strobes_drop", {29'b0, ren, wen, busy}, 0);
    chk("rst_events_left", bq.size(), 0);
    bq.delete(); rq.delete(); tq.delete();
    refm[12'h341] = pc & ~32'd3;
    refm[12'h342] = cause;
    repeat (2) @(negedge clk);
    chk_reset_outs("mid_rst");
    rst = 0;
  endtask
`endif

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    rst = 0;
    foreach (csrs[k]) preset(csrs[k], $urandom);
    preset(12'h305, 32'h0000_0040);
    csr_op(3'b001, 12'h305, 5'd3, 32'h8000_0100);
    csr_op(3'b010, 12'h304, 5'd0, $urandom);
    preset(12'h300, 32'h0000_1888);
    csr_op(3'b111, 12'h300, 5'd8, $urandom);
    csr_op(3'b100, 12'h300, 5'd5, $urandom);
    csr_op(3'b000, 12'h304, 5'd1, $urandom);
    csr_op(3'b110, 12'h340, 5'd0, $urandom);
    csr_op(3'b011, 12'h340, 5'd9, 32'hffff_0000);
`ifdef CSR_TRAP_EN
    preset(12'h300, 32'h0000_0008);
    preset(12'h305, 32'h0000_1001);
    trap_seq(32'h8000_0007, 32'h0000_2006, 0);
    trap_seq(32'h0000_0002, 32'h0000_3000, 0);
    trap_reset(32'h8000_000b, 32'h0000_4002);
    trap_seq(32'h8000_0003, 32'h0000_5008, 1);
`else
    trap = 1; tcause = $urandom; tpc = $urandom;
    csr_op(3'b001, 12'h340, 5'd1, 32'h1234_5678);
    trap = 0;
`endif
    for (int n = 0; n < 40; n++) begin
      logic [2:0] f;
      logic [4:0] s;
      f = 3'($urandom_range(0, 7));
      s = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      csr_op(f, csrs[$urandom_range(0, 5)], s, $urandom);
`ifdef CSR_TRAP_EN
      if (n % 8 == 7) trap_seq($urandom, $urandom, $urandom_range(0, 1) == 1);
`endif
    end
    wait_idle();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
